// File: rtl/cv32e40p_nmr_redundancy_mgr_ft.sv
// N-replica redundancy manager: bitwise vote over the active set, per-replica health counters,
// spare swap-in and TMR -> DMR -> FAIL degradation. Fault-injection ports: CV32E40P_NMR_FAULT_INJ_EN.
module cv32e40p_nmr_redundancy_mgr_ft #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_REP     = 4,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned THRESH    = 16,
   parameter int unsigned DECAY_PER = 64,
   parameter int unsigned SWAP_CYC  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_i,
   input  logic [N_REP*WIDTH-1:0]   result_i,
`ifdef CV32E40P_NMR_FAULT_INJ_EN
   input  logic                     inj_en_i,
   input  logic [$clog2(N_REP)-1:0] inj_rep_i,
   input  logic [WIDTH-1:0]         inj_mask_i,
`endif
   output logic [WIDTH-1:0]         voted_o,
   output logic                     ready_o,
   output logic                     err_detected_o,
   output logic                     err_corrected_o,
   output logic [N_REP-1:0]         clock_en_o,
   output logic [N_REP-1:0]         faulty_o,
   output logic [N_REP-1:0]         fault_pulse_o,
   output logic [1:0]               mode_o
);

   localparam int unsigned IDX_W = $clog2(N_REP);
   localparam int unsigned CL_W  = $clog2(DECAY_PER + 1);
   localparam int unsigned SW_W  = $clog2(SWAP_CYC + 1);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
   localparam logic [CL_W-1:0]  DECAY_C  = CL_W'(DECAY_PER - 1);
   localparam logic [SW_W-1:0]  SWAP_C   = SW_W'(SWAP_CYC - 1);
   localparam logic [N_REP-1:0] ACT_RST  = N_REP'(3'b111);

   typedef enum logic [1:0] {
      MODE_TMR    = 2'd0,
      MODE_DMR    = 2'd1,
      MODE_RECONF = 2'd2,
      MODE_FAIL   = 2'd3
   } mode_e;

   mode_e              mode_r, mode_s;
   logic [N_REP-1:0]   active_r, active_s;
   logic [N_REP-1:0]   faulty_r, faulty_s;
   logic [N_REP-1:0]   pulse_r;
   logic               ready_r;
   logic [CNT_W-1:0]   cnt_r [N_REP];
   logic [CNT_W-1:0]   cnt_s [N_REP];
   logic [CNT_W-1:0]   dmr_cnt_r, dmr_cnt_s;
   logic [CL_W-1:0]    clean_r, clean_s;
   logic [SW_W-1:0]    swap_r, swap_s;

   logic [WIDTH-1:0]   res_s [N_REP];
   logic [WIDTH-1:0]   voted_tmr_s;
   logic [3:0]         ones_s;
   logic [IDX_W-1:0]   lo_s, hi_s;
   logic [N_REP-1:0]   mismatch_s;
   logic               ops_s, decay_s;

   // lowest-indexed n replicas that are not marked faulty
   function automatic logic [N_REP-1:0] pick_active(input logic [N_REP-1:0] faulty, input int unsigned n);
      logic [N_REP-1:0] m;
      int unsigned      k;
      m = '0;
      k = 0;
      for (int r = 0; r < N_REP; r++) begin
         if (!faulty[r] && (k < n)) begin
            m[r] = 1'b1;
            k    = k + 1;
         end
      end
      return m;
   endfunction

   function automatic int unsigned popcount(input logic [N_REP-1:0] v);
      int unsigned c;
      c = 0;
      for (int r = 0; r < N_REP; r++) c = c + int'(v[r]);
      return c;
   endfunction

   // effective replica results (optionally with an injected bit flip)
   always_comb begin
      for (int r = 0; r < N_REP; r++) begin
`ifdef CV32E40P_NMR_FAULT_INJ_EN
         res_s[r] = (inj_en_i && (int'(inj_rep_i) == r)) ? (result_i[r*WIDTH +: WIDTH] ^ inj_mask_i)
                                                           : result_i[r*WIDTH +: WIDTH];
`else
         res_s[r] = result_i[r*WIDTH +: WIDTH];
`endif
      end
   end

   // vote, error flags and per-replica mismatch attribution
   always_comb begin
      voted_tmr_s     = '0;
      ones_s          = 4'd0;
      lo_s            = '0;
      hi_s            = '0;
      mismatch_s      = '0;
      voted_o         = '0;
      err_detected_o  = 1'b0;
      err_corrected_o = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
         ones_s = 4'd0;
         for (int r = 0; r < N_REP; r++) ones_s = ones_s + {3'b000, active_r[r] & res_s[r][b]};
         voted_tmr_s[b] = (ones_s >= 4'd2);
      end
      for (int r = N_REP - 1; r >= 0; r--) lo_s = active_r[r] ? IDX_W'(r) : lo_s;
      for (int r = 0; r < N_REP; r++)      hi_s = active_r[r] ? IDX_W'(r) : hi_s;
      case (mode_r)
         MODE_TMR: begin
            for (int r = 0; r < N_REP; r++)
               mismatch_s[r] = valid_i && active_r[r] && (res_s[r] != voted_tmr_s);
            voted_o         = voted_tmr_s;
            err_detected_o  = |mismatch_s;
            err_corrected_o = |mismatch_s;
         end
         MODE_DMR: begin
            voted_o        = res_s[lo_s];
            err_detected_o = valid_i && (res_s[lo_s] != res_s[hi_s]);
         end
         default: begin
            voted_o = '0;
         end
      endcase
   end

   // health counters, decay window and mode sequencing
   always_comb begin
      mode_s    = mode_r;
      active_s  = active_r;
      faulty_s  = faulty_r;
      cnt_s     = cnt_r;
      dmr_cnt_s = dmr_cnt_r;
      clean_s   = clean_r;
      swap_s    = swap_r;
      decay_s   = 1'b0;
      ops_s     = valid_i && ((mode_r == MODE_TMR) || (mode_r == MODE_DMR));

      if (ops_s && err_detected_o) begin
         clean_s = '0;
      end else if (ops_s && (clean_r == DECAY_C)) begin
         clean_s = '0;
         decay_s = 1'b1;
      end else if (ops_s) begin
         clean_s = clean_r + CL_W'(1);
      end else begin
         clean_s = clean_r;
      end

      for (int r = 0; r < N_REP; r++) begin
         if (faulty_r[r]) begin
            cnt_s[r] = cnt_r[r];
         end else if (mismatch_s[r]) begin
            cnt_s[r]    = (cnt_r[r] >= THRESH_C) ? THRESH_C : cnt_r[r] + CNT_W'(1);
            faulty_s[r] = (cnt_s[r] == THRESH_C);
         end else if (decay_s && active_r[r] && (cnt_r[r] != '0)) begin
            cnt_s[r] = cnt_r[r] - CNT_W'(1);
         end else begin
            cnt_s[r] = cnt_r[r];
         end
      end

      // DMR cannot tell which replica is wrong, so one shared counter tracks the pair
      if ((mode_r == MODE_DMR) && ops_s && err_detected_o) begin
         dmr_cnt_s = (dmr_cnt_r >= THRESH_C) ? THRESH_C : dmr_cnt_r + CNT_W'(1);
      end else if ((mode_r == MODE_DMR) && decay_s && (dmr_cnt_r != '0)) begin
         dmr_cnt_s = dmr_cnt_r - CNT_W'(1);
      end else begin
         dmr_cnt_s = dmr_cnt_r;
      end

      case (mode_r)
         MODE_TMR: begin
            if (faulty_s != faulty_r) begin
               mode_s   = MODE_RECONF;
               swap_s   = '0;
               active_s = active_r | pick_active(faulty_s, 3);
            end else begin
               mode_s = MODE_TMR;
            end
         end
         MODE_DMR: begin
            if (dmr_cnt_s == THRESH_C) begin
               mode_s   = MODE_FAIL;
               active_s = '0;
            end else begin
               mode_s = MODE_DMR;
            end
         end
         MODE_RECONF: begin
            if (swap_r != SWAP_C) begin
               swap_s = swap_r + SW_W'(1);
            end else if (popcount(~faulty_r) >= 3) begin
               mode_s   = MODE_TMR;
               active_s = pick_active(faulty_r, 3);
            end else if (popcount(~faulty_r) == 2) begin
               mode_s   = MODE_DMR;
               active_s = pick_active(faulty_r, 2);
            end else begin
               mode_s   = MODE_FAIL;
               active_s = '0;
            end
         end
         default: begin
            mode_s   = MODE_FAIL;
            active_s = '0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r    <= MODE_TMR;
         active_r  <= ACT_RST;
         faulty_r  <= '0;
         pulse_r   <= '0;
         ready_r   <= 1'b1;
         cnt_r     <= '{default: '0};
         dmr_cnt_r <= '0;
         clean_r   <= '0;
         swap_r    <= '0;
      end else begin
         mode_r    <= mode_s;
         active_r  <= active_s;
         faulty_r  <= faulty_s;
         pulse_r   <= faulty_s & ~faulty_r;
         ready_r   <= (mode_s == MODE_TMR) || (mode_s == MODE_DMR);
         cnt_r     <= cnt_s;
         dmr_cnt_r <= dmr_cnt_s;
         clean_r   <= clean_s;
         swap_r    <= swap_s;
      end
   end

   assign ready_o       = ready_r;
   assign clock_en_o    = active_r;
   assign faulty_o      = faulty_r;
   assign fault_pulse_o = pulse_r;
   assign mode_o        = mode_r;

endmodule
